ahb_master: RTL and testbench

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_master.sv | 123 ++++++++++++
 tb/tb_ahb_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
// AHB-Lite master: turns host SINGLE/INCR4 commands into pipelined AHB transfers with per-beat responses.
// Optional AHB_MASTER_ERR_ABORT_EN: an ERROR response cancels the remaining beats of a burst.
module ahb_master (
  input  logic         h_clk,
  input  logic         h_resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_addr,
  input  logic         cmd_write,
  input  logic [2:0]   cmd_burst,
  input  logic [2:0]   cmd_size,
  input  logic [127:0] cmd_wdata,
  input  logic [3:0]   cmd_wstrb,
  output logic [31:0]  h_addr,
  output logic [2:0]   h_burst,
  output logic [2:0]   h_size,
  output logic [1:0]   h_trans,
  output logic         h_write,
  output logic [31:0]  h_wdata,
  output logic [3:0]   h_wstrb,
  input  logic [31:0]  h_rdata,
  input  logic         h_ready,
  input  logic         h_resp,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output logic         rsp_last
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SEQ, S_DATA} state_t;

  state_t       state_reg, state_next;
  logic [127:0] wdata_reg;
  logic [3:0]   wstrb_reg;
  logic [1:0]   beat_reg;
  logic         incr4_reg;
  logic         cmd_fire, addr_accept, data_done, abort;

  // Gating with the reset input keeps cmd_ready low while reset is held.
  assign cmd_ready   = h_resetn && ((state_reg == S_IDLE) || ((state_reg == S_DATA) && h_ready));
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign addr_accept = ((state_reg == S_FIRST) || (state_reg == S_SEQ)) && h_ready;
  assign data_done   = ((state_reg == S_SEQ) || (state_reg == S_DATA)) && h_ready;

`ifdef AHB_MASTER_ERR_ABORT_EN
  // First ERROR cycle of a mid-burst data phase: drop the pending address phase.
  assign abort = (state_reg == S_SEQ) && h_resp && !h_ready;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (cmd_fire) state_next = S_FIRST;
      S_FIRST: if (h_ready) state_next = incr4_reg ? S_SEQ : S_DATA;
      S_SEQ:   if (abort || (h_ready && (beat_reg == 2'd3))) state_next = S_DATA;
      S_DATA:  if (h_ready) state_next = cmd_fire ? S_FIRST : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      h_addr    <= '0;
      h_burst   <= '0;
      h_size    <= '0;
      h_trans   <= TRANS_IDLE;
      h_write   <= 1'b0;
      h_wdata   <= '0;
      h_wstrb   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      beat_reg  <= '0;
      incr4_reg <= 1'b0;
    end else begin
      // h_write still belongs to the completing beat when a new command is captured.
      rsp_valid <= data_done;
      rsp_rdata <= (data_done && !h_write) ? h_rdata : '0;
      rsp_err   <= data_done && h_resp;
      rsp_last  <= data_done && (state_reg == S_DATA);
      if (cmd_fire) begin
        h_addr    <= cmd_addr;
        h_burst   <= (cmd_burst == BURST_INCR4) ? BURST_INCR4 : BURST_SINGLE;
        h_size    <= cmd_size;
        h_write   <= cmd_write;
        h_trans   <= TRANS_NONSEQ;
        incr4_reg <= (cmd_burst == BURST_INCR4);
        wdata_reg <= cmd_wdata;
        wstrb_reg <= cmd_wstrb;
        beat_reg  <= 2'd0;
      end else if (addr_accept) begin
        h_wdata <= wdata_reg[{beat_reg, 5'b0} +: 32];
        h_wstrb <= wstrb_reg;
        if (incr4_reg && (beat_reg != 2'd3)) begin
          h_addr   <= h_addr + (32'd1 << h_size);
          h_trans  <= TRANS_SEQ;
          beat_reg <= beat_reg + 2'd1;
        end else begin
          h_trans <= TRANS_IDLE;
        end
      end else if (abort) begin
        h_trans <= TRANS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed scenarios plus random commands against a burst-level reference model.
// Honours AHB_MASTER_ERR_ABORT_EN the same way the design does.
module tb_ahb_master;

  logic         h_clk = 1'b0;
  logic         h_resetn;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [2:0]   cmd_burst, cmd_size;
  logic [127:0] cmd_wdata;
  logic [3:0]   cmd_wstrb;
  logic [31:0]  h_addr, h_wdata, h_rdata, rsp_rdata;
  logic [2:0]   h_burst, h_size;
  logic [1:0]   h_trans;
  logic         h_write, h_ready, h_resp, rsp_valid, rsp_err, rsp_last;
  logic [3:0]   h_wstrb;

  ahb_master dut (
    .h_clk(h_clk), .h_resetn(h_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size), .h_trans(h_trans), .h_write(h_write),
    .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_rdata(h_rdata), .h_ready(h_ready), .h_resp(h_resp),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last)
  );

  always #5 h_clk = ~h_clk;

  typedef struct {
    logic [31:0] addr; logic wr; logic [2:0] burst; logic [2:0] size;
    logic [127:0] wdata; logic [3:0] wstrb;
    int wait_beat; int wait_n; int err_beat; int gap;
  } cmd_t;
  typedef struct {
    logic [31:0] addr; logic [1:0] trans; logic [2:0] burst; logic [2:0] size; logic wr;
    logic [31:0] wdata; logic [3:0] wstrb; int waits; bit err; bit last;
  } beat_t;
  typedef struct { logic [31:0] rdata; bit err; bit last; } rsp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  cmd_t  cmdq[$];
  beat_t expq[$];
  rsp_t  rspq[$];
  int    nonseq_cyc[$];
  beat_t dp;
  bit    dp_active = 0;
  int    dp_waits = 0;
  int    err_stage = 0;
  bit    second_err = 0;
  int    gap_cnt = 0;
  bit    exp_nonseq = 0;
  logic [31:0] exp_nonseq_addr;
  bit    prev_addr_stall = 0, prev_data_stall = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic w, input logic [2:0] b, input logic [2:0] sz,
                          input logic [127:0] wd, input logic [3:0] st,
                          input int wb, input int wn, input int eb, input int gp);
    cmd_t c;
    c.addr = a; c.wr = w; c.burst = b; c.size = sz; c.wdata = wd; c.wstrb = st;
    c.wait_beat = wb; c.wait_n = wn; c.err_beat = eb; c.gap = gp;
    if (cmdq.size() == 0) gap_cnt = gp;
    cmdq.push_back(c);
  endtask

  // Reference model: a command becomes its list of expected address beats.
  task automatic expand(input cmd_t c);
    int n, nis;
    logic [31:0] step;
    beat_t b;
    n = (c.burst == 3'b011) ? 4 : 1;
    nis = n;
`ifdef AHB_MASTER_ERR_ABORT_EN
    if (c.err_beat >= 0 && c.err_beat < n) nis = c.err_beat + 1;
`endif
    step = 32'd1 << c.size;
    for (int i = 0; i < nis; i++) begin
      b.addr  = c.addr + step * 32'(i);
      b.trans = (i == 0) ? 2'b10 : 2'b11;
      b.burst = (n == 4) ? 3'b011 : 3'b000;
      b.size  = c.size;
      b.wr    = c.wr;
      b.wdata = c.wdata[32*i +: 32];
      b.wstrb = c.wstrb;
      b.waits = (i == c.wait_beat) ? c.wait_n : 0;
      b.err   = (i == c.err_beat);
      b.last  = (i == nis - 1);
      expq.push_back(b);
    end
    $display("[TB] cmd addr=%08h write=%0d burst=%0d size=%0d beats=%0d", c.addr, c.wr, c.burst, c.size, nis);
  endtask

  function automatic bit busy();
    return (cmdq.size() != 0) || (expq.size() != 0) || (rspq.size() != 0) || dp_active;
  endfunction

  // One clock cycle: observe at the falling edge, then drive the next cycle's inputs after the rising edge.
  task automatic cycle();
    rsp_t r;
    beat_t b;
    cmd_t c;
    bit nr, nresp, nv;
    @(negedge h_clk);
    cyc++;
    if (prev_addr_stall) chk("addr_hold", h_addr, prev_addr);
    if (prev_data_stall) begin
      chk("wdata_hold", h_wdata, prev_wdata);
      chk("wstrb_hold", h_wstrb, prev_wstrb);
    end
    chk("no_busy", h_trans == 2'b01, 0);
    if (exp_nonseq) begin
      chk("nonseq_trans", h_trans, 2'b10);
      chk("nonseq_addr", h_addr, exp_nonseq_addr);
      exp_nonseq = 0;
    end
`ifdef AHB_MASTER_ERR_ABORT_EN
    if (second_err) chk("abort_idle", h_trans, 2'b00);
`endif
    if (rspq.size() > 0) begin
      r = rspq.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, r.rdata);
      chk("rsp_err", rsp_err, r.err);
      chk("rsp_last", rsp_last, r.last);
    end else begin
      chk("rsp_quiet", rsp_valid, 0);
    end
    prev_data_stall = 0;
    if (dp_active) begin
      if (h_ready) begin
        if (dp.wr) begin
          chk("h_wdata", h_wdata, dp.wdata);
          chk("h_wstrb", h_wstrb, dp.wstrb);
        end
        r.rdata = dp.wr ? 32'd0 : h_rdata;
        r.err   = dp.err;
        r.last  = dp.last;
        rspq.push_back(r);
        dp_active = 0;
      end else begin
        prev_data_stall = dp.wr;
        prev_wdata = h_wdata;
        prev_wstrb = h_wstrb;
      end
    end
    prev_addr_stall = (h_trans != 2'b00) && !h_ready;
    prev_addr = h_addr;
    if (h_trans != 2'b00 && h_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_addr", h_trans, 2'b00);
      end else begin
        b = expq.pop_front();
        chk("h_addr", h_addr, b.addr);
        chk("h_trans", h_trans, b.trans);
        chk("h_burst", h_burst, b.burst);
        chk("h_size", h_size, b.size);
        chk("h_write", h_write, b.wr);
        if (h_trans == 2'b10) nonseq_cyc.push_back(cyc);
        dp = b;
        dp_active = 1;
        dp_waits = b.waits;
        err_stage = 0;
      end
    end
    if (cmd_valid && cmd_ready) begin
      c = cmdq.pop_front();
      expand(c);
      exp_nonseq = 1;
      exp_nonseq_addr = c.addr;
      gap_cnt = (cmdq.size() > 0) ? cmdq[0].gap : 0;
    end
    second_err = 0;
    nr = 1;
    nresp = 0;
    if (dp_active) begin
      if (dp_waits > 0) begin
        nr = 0;
        dp_waits--;
      end else if (dp.err) begin
        nresp = 1;
        if (err_stage == 0) begin
          nr = 0;
          err_stage = 1;
        end else begin
          second_err = 1;
        end
      end
    end
    nv = 0;
    if (cmdq.size() > 0) begin
      if (gap_cnt > 0) gap_cnt--;
      else nv = 1;
    end
    @(posedge h_clk);
    #1;
    h_ready = nr;
    h_resp = nresp;
    h_rdata = $urandom;
    cmd_valid = nv;
    if (nv) begin
      cmd_addr = cmdq[0].addr; cmd_write = cmdq[0].wr; cmd_burst = cmdq[0].burst;
      cmd_size = cmdq[0].size; cmd_wdata = cmdq[0].wdata; cmd_wstrb = cmdq[0].wstrb;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", busy(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr_phase"}, {h_trans, h_addr, h_burst, h_size, h_write}, 0);
    chk({tag, "_data_phase"}, {h_wdata, h_wstrb}, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_rdata, rsp_err, rsp_last}, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  initial begin
    logic [127:0] wd;
    h_resetn = 1'b0;
    cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_burst = 0; cmd_size = 0; cmd_wdata = 0; cmd_wstrb = 0;
    h_rdata = 0; h_ready = 1; h_resp = 0;

    // Power-on reset.
    repeat (2) @(posedge h_clk);
    #1;
    check_reset_values("por");
    h_resetn = 1'b1;
    #2;
    chk("cmd_ready_after_por", cmd_ready, 1);

    // SINGLE word write, zero-wait slave.
    push_cmd(32'h4, 1, 3'b000, 3'b010, 128'hDEADBEEF, 4'hF, -1, 0, -1, 0);
    run_until_idle(50);

    // INCR4 word read at 0x10.
    push_cmd(32'h10, 0, 3'b011, 3'b010, 128'h0, 4'hF, -1, 0, -1, 0);
    run_until_idle(50);

    // INCR4 halfword write wrapping past 0xFFFFFFFF.
    wd = 128'h44440004_33330003_22220002_11110001;
    push_cmd(32'hFFFF_FFFC, 1, 3'b011, 3'b001, wd, 4'h3, -1, 0, -1, 0);
    run_until_idle(50);

    // Two wait states on the second beat of an INCR4 write.
    wd = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    push_cmd(32'h100, 1, 3'b011, 3'b010, wd, 4'hF, 1, 2, -1, 0);
    run_until_idle(50);

    // ERROR on the first beat of an INCR4 write.
    wd = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    push_cmd(32'h200, 1, 3'b011, 3'b010, wd, 4'hF, -1, 0, 0, 0);
    run_until_idle(50);

    // Back-to-back SINGLEs: second NONSEQ issued straight from the final data phase.
    nonseq_cyc.delete();
    push_cmd(32'h300, 1, 3'b000, 3'b010, 128'h11111111, 4'hF, -1, 0, -1, 0);
    push_cmd(32'h304, 0, 3'b000, 3'b010, 128'h0, 4'hF, -1, 0, -1, 0);
    run_until_idle(50);
    chk("b2b_count", nonseq_cyc.size(), 2);
    if (nonseq_cyc.size() == 2) chk("b2b_gap", nonseq_cyc[1] - nonseq_cyc[0], 2);

    // Reset pulse in the middle of an INCR4 read.
    push_cmd(32'h400, 0, 3'b011, 3'b010, 128'h0, 4'hF, -1, 0, -1, 0);
    repeat (4) cycle();
    h_resetn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    cmdq.delete(); expq.delete(); rspq.delete();
    dp_active = 0; exp_nonseq = 0; second_err = 0; prev_addr_stall = 0; prev_data_stall = 0;
    cmd_valid = 0; h_ready = 1; h_resp = 0;
    @(posedge h_clk);
    #1;
    check_reset_values("mid_rst_held");
    h_resetn = 1'b1;
    #2;
    chk("cmd_ready_after_rst", cmd_ready, 1);
    repeat (5) cycle();

    // Random commands, wait states, errors and gaps.
    for (int i = 0; i < 24; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      push_cmd($urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 2)), wd, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
               $urandom_range(0, 2));
    end
    run_until_idle(3000);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
